// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RV32IM fetch stage: fetch PC, credit-limited IMem requests, instruction queue, redirect flush; FETCH_BYPASS_EN enables 0-cycle response bypass
module instr_fetch_unit #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      INSTR_WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned      QUEUE_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   IMem_Req_Valid,
  input  logic                   IMem_Req_Ready,
  output logic [WIDTH-1:0]       IMem_Req_Addr,
  input  logic                   IMem_Rsp_Valid,
  input  logic [INSTR_WIDTH-1:0] IMem_Rsp_Data,
  input  logic                   Redirect_Valid,
  input  logic [WIDTH-1:0]       Redirect_PC,
  output logic                   Instr_Valid,
  input  logic                   Instr_Ready,
  output logic [INSTR_WIDTH-1:0] Instr_RV32IM,
  output logic [WIDTH-1:0]       Instr_PC
);

  localparam int unsigned PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [INSTR_WIDTH-1:0] NOP     = INSTR_WIDTH'(32'h0000_0013);
  localparam logic [CW-1:0]          DEPTH_C = CW'(QUEUE_DEPTH);
  localparam logic [CW:0]            DEPTH_W = (CW+1)'(QUEUE_DEPTH);

  // Control state
  logic             started_q;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]    outstanding_q, outstanding_d;
  logic [CW-1:0]    drop_q, drop_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] last_pc_q;

  // In-flight PC FIFO: one entry per handshaken request, popped by every response
  logic [WIDTH-1:0] infl_pc_q [QUEUE_DEPTH];
  logic [PW-1:0]    infl_wr_q, infl_rd_q;

  // Instruction queue toward decode
  logic [INSTR_WIDTH-1:0] q_instr_q [QUEUE_DEPTH];
  logic [WIDTH-1:0]       q_pc_q    [QUEUE_DEPTH];
  logic [PW-1:0]          q_wr_q, q_rd_q;

  logic             req_hs;
  logic             rsp_drop;
  logic             rsp_keep;
  logic             bypass;
  logic             q_push;
  logic             q_pop;
  logic             q_empty;
  logic             q_full;
  logic [CW:0]      credit_used;
  logic [WIDTH-1:0] redirect_tgt;

  // Credit covers both unreturned requests and queued entries, so a response always has a slot
  assign credit_used    = {1'b0, outstanding_q} + {1'b0, count_q};
  assign IMem_Req_Valid = started_q && (credit_used < DEPTH_W) && !Redirect_Valid;
  assign IMem_Req_Addr  = fetch_pc_q;
  assign req_hs         = IMem_Req_Valid && IMem_Req_Ready;
  assign redirect_tgt   = {Redirect_PC[WIDTH-1:2], 2'b00};

  // A response is discarded if it belongs to a pre-redirect request or lands on a redirect cycle
  assign rsp_drop = IMem_Rsp_Valid && (Redirect_Valid || (drop_q != '0));
  assign rsp_keep = IMem_Rsp_Valid && !rsp_drop;

  assign q_empty = (count_q == '0);
  assign q_full  = (count_q == DEPTH_C);

`ifdef FETCH_BYPASS_EN
  assign bypass = rsp_keep && q_empty && Instr_Ready;
`else
  assign bypass = 1'b0;
`endif

  assign q_push = rsp_keep && !bypass;
  assign q_pop  = !q_empty && Instr_Ready;

  // Decode-facing outputs: queue head, NOP with held PC when empty, optional same-cycle bypass
  always_comb begin
    Instr_Valid  = !q_empty;
    Instr_RV32IM = q_empty ? NOP : q_instr_q[q_rd_q];
    Instr_PC     = q_empty ? last_pc_q : q_pc_q[q_rd_q];
`ifdef FETCH_BYPASS_EN
    if (bypass) begin
      Instr_Valid  = 1'b1;
      Instr_RV32IM = IMem_Rsp_Data;
      Instr_PC     = infl_pc_q[infl_rd_q];
    end
`endif
  end

  // Next state for fetch PC, outstanding/drop counters and queue occupancy; redirect overrides all
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    count_d       = count_q;

    if (req_hs) begin
      fetch_pc_d = fetch_pc_q + WIDTH'(4);
    end

    if (req_hs && !IMem_Rsp_Valid) begin
      outstanding_d = outstanding_q + CW'(1);
    end else if (!req_hs && IMem_Rsp_Valid) begin
      outstanding_d = outstanding_q - CW'(1);
    end

    if (IMem_Rsp_Valid && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end

    if (q_push && !q_pop) begin
      count_d = count_q + CW'(1);
    end else if (!q_push && q_pop) begin
      count_d = count_q - CW'(1);
    end

    // No request issues on a redirect cycle, so everything still outstanding afterwards is stale
    if (Redirect_Valid) begin
      fetch_pc_d = redirect_tgt;
      drop_d     = outstanding_d;
      count_d    = '0;
    end
  end

  // Control registers; requests start the cycle after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q     <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      last_pc_q     <= '0;
    end else begin
      started_q     <= 1'b1;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
      if (Instr_Valid) begin
        last_pc_q <= Instr_PC;
      end
    end
  end

  // FIFO pointers; the in-flight FIFO survives a redirect so dropped responses still pop their PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl_wr_q <= '0;
      infl_rd_q <= '0;
      q_wr_q    <= '0;
      q_rd_q    <= '0;
    end else begin
      if (req_hs) begin
        infl_wr_q <= infl_wr_q + PW'(1);
      end
      if (IMem_Rsp_Valid) begin
        infl_rd_q <= infl_rd_q + PW'(1);
      end
      if (Redirect_Valid) begin
        q_wr_q <= '0;
        q_rd_q <= '0;
      end else begin
        if (q_push) begin
          q_wr_q <= q_wr_q + PW'(1);
        end
        if (q_pop) begin
          q_rd_q <= q_rd_q + PW'(1);
        end
      end
    end
  end

  // Storage arrays; contents are only meaningful under the pointers/counters above
  always_ff @(posedge clk) begin
    if (req_hs) begin
      infl_pc_q[infl_wr_q] <= fetch_pc_q;
    end
    if (q_push) begin
      q_instr_q[q_wr_q] <= IMem_Rsp_Data;
      q_pc_q[q_wr_q]    <= infl_pc_q[infl_rd_q];
    end
  end

  // Queue overflow or a response with nothing outstanding means the credit scheme was violated
  a_queue_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(q_push && !q_pop && q_full));
  a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
    !(IMem_Rsp_Valid && (outstanding_q == '0)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized self-checking bench for instr_fetch_unit with in-order memory and stream model
module tb_instr_fetch_unit;

  localparam int          QD     = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        IMem_Req_Valid;
  logic        IMem_Req_Ready = 1'b0;
  logic [31:0] IMem_Req_Addr;
  logic        IMem_Rsp_Valid = 1'b0;
  logic [31:0] IMem_Rsp_Data = '0;
  logic        Redirect_Valid = 1'b0;
  logic [31:0] Redirect_PC = '0;
  logic        Instr_Valid;
  logic        Instr_Ready = 1'b0;
  logic [31:0] Instr_RV32IM;
  logic [31:0] Instr_PC;

  instr_fetch_unit #(
    .WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(RST_PC), .QUEUE_DEPTH(QD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .IMem_Req_Valid(IMem_Req_Valid), .IMem_Req_Ready(IMem_Req_Ready), .IMem_Req_Addr(IMem_Req_Addr),
    .IMem_Rsp_Valid(IMem_Rsp_Valid), .IMem_Rsp_Data(IMem_Rsp_Data),
    .Redirect_Valid(Redirect_Valid), .Redirect_PC(Redirect_PC),
    .Instr_Valid(Instr_Valid), .Instr_Ready(Instr_Ready),
    .Instr_RV32IM(Instr_RV32IM), .Instr_PC(Instr_PC)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Memory model: in-order pending requests, each answerable from the cycle after its handshake
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] salt = '0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ salt;
  endfunction

  // Stimulus knobs (percent probabilities) and one-shot redirect
  int          p_req_rdy = 100, p_rsp = 100, p_instr_rdy = 100, p_redir = 0;
  bit          force_redir = 1'b0;
  logic [31:0] force_tgt = '0;

  // Reference model: expected next request address and next delivered PC of the fetch stream
  logic [31:0] exp_req = RST_PC;
  logic [31:0] exp_pc = RST_PC;
  logic [31:0] last_vis_pc = '0;
  logic [31:0] stall_addr = '0;
  logic [31:0] last_hs_addr = 32'hFFFF_FFFF;
  logic [31:0] deliv_pcs[$];
  bit          stall_prev = 1'b0, idle_chk = 1'b0;
  bit          seen_req_valid = 1'b0, seen_rsp_valid = 1'b0, seen_instr_valid = 1'b0;
  int          cyc = 0, n_hs = 0, n_deliv = 0;

  function automatic logic [31:0] dpc(input int i);
    return (deliv_pcs.size() > i) ? deliv_pcs[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    IMem_Req_Ready = ($urandom_range(99) < p_req_rdy);
    Instr_Ready    = ($urandom_range(99) < p_instr_rdy);
    if (force_redir || ($urandom_range(99) < p_redir)) begin
      Redirect_Valid = 1'b1;
      Redirect_PC    = force_redir ? force_tgt : $urandom();
    end else begin
      Redirect_Valid = 1'b0;
      Redirect_PC    = $urandom();
    end
    force_redir = 1'b0;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc && $urandom_range(99) < p_rsp) begin
      IMem_Rsp_Valid = 1'b1;
      IMem_Rsp_Data  = word_of(pend_addr[0]);
    end else begin
      IMem_Rsp_Valid = 1'b0;
      IMem_Rsp_Data  = $urandom();
    end
    @(negedge clk);
    seen_req_valid   = IMem_Req_Valid;
    seen_rsp_valid   = IMem_Rsp_Valid;
    seen_instr_valid = Instr_Valid;
    if (idle_chk) check("valid_after_redirect", {31'b0, Instr_Valid}, 32'd0);
    idle_chk = Redirect_Valid;
    if (Redirect_Valid) begin
      check("req_in_redirect", {31'b0, IMem_Req_Valid}, 32'd0);
    end else if (stall_prev) begin
      check("req_hold_valid", {31'b0, IMem_Req_Valid}, 32'd1);
      check("req_hold_addr", IMem_Req_Addr, stall_addr);
    end
    stall_prev = IMem_Req_Valid && !IMem_Req_Ready;
    stall_addr = IMem_Req_Addr;
    if (!Instr_Valid) begin
      check("nop_when_empty", Instr_RV32IM, NOP);
      check("pc_hold_when_empty", Instr_PC, last_vis_pc);
    end else begin
      last_vis_pc = Instr_PC;
    end
    if (IMem_Rsp_Valid) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (IMem_Req_Valid && IMem_Req_Ready) begin
      check("req_addr", IMem_Req_Addr, exp_req);
      pend_addr.push_back(IMem_Req_Addr);
      pend_due.push_back(cyc + 1);
      last_hs_addr = IMem_Req_Addr;
      exp_req = exp_req + 32'd4;
      n_hs++;
    end
    check("credit_bound", {31'b0, pend_addr.size() <= QD}, 32'd1);
    if (Instr_Valid && Instr_Ready) begin
      check("instr_pc", Instr_PC, exp_pc);
      check("instr_word", Instr_RV32IM, word_of(exp_pc));
      deliv_pcs.push_back(Instr_PC);
      exp_pc = exp_pc + 32'd4;
      n_deliv++;
    end
    if (Redirect_Valid) begin
      exp_req = {Redirect_PC[31:2], 2'b00};
      exp_pc  = exp_req;
    end
  endtask

  task automatic do_reset(input logic [31:0] new_salt);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    IMem_Req_Ready = 1'b0; IMem_Rsp_Valid = 1'b0; Redirect_Valid = 1'b0; Instr_Ready = 1'b0;
    #1;
    check("rst_instr_valid", {31'b0, Instr_Valid}, 32'd0);
    check("rst_instr_nop", Instr_RV32IM, NOP);
    check("rst_instr_pc", Instr_PC, 32'd0);
    check("rst_req_valid", {31'b0, IMem_Req_Valid}, 32'd0);
    pend_addr.delete(); pend_due.delete(); deliv_pcs.delete();
    exp_req = RST_PC; exp_pc = RST_PC; last_vis_pc = '0;
    stall_prev = 1'b0; idle_chk = 1'b0; last_hs_addr = 32'hFFFF_FFFF;
    salt = new_salt;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("req_before_start", {31'b0, IMem_Req_Valid}, 32'd0);
  endtask

  initial begin
    int d0, h0;

    // Streaming from reset, 1-cycle memory, decode always ready
    do_reset(32'h0);
    p_req_rdy = 100; p_rsp = 100; p_instr_rdy = 100; p_redir = 0;
    step();
    check("first_req_valid", {31'b0, seen_req_valid}, 32'd1);
    check("first_req_addr", last_hs_addr, RST_PC);
    d0 = n_deliv;
    repeat (30) step();
    check("stream_rate", {31'b0, (n_deliv - d0) >= 18}, 32'd1);
    check("stream_first_pcs", dpc(2), 32'h8);

    // Decode stalled: credit limits handshakes to the queue depth
    do_reset(32'h0);
    p_instr_rdy = 0;
    h0 = n_hs;
    repeat (10) step();
    check("fill_req_count", n_hs - h0, QD);
    check("req_valid_when_full", {31'b0, seen_req_valid}, 32'd0);
    p_instr_rdy = 100;
    repeat (5) step();
    check("drain_pc0", dpc(0), 32'h0);
    check("drain_pc1", dpc(1), 32'h4);

    // Redirect with two responses outstanding: both dropped
    do_reset(32'h0);
    p_rsp = 0;
    repeat (4) step();
    check("two_outstanding", pend_addr.size(), 2);
    deliv_pcs.delete();
    force_redir = 1'b1; force_tgt = 32'h100;
    step();
    p_rsp = 100;
    repeat (8) step();
    check("redir_first_pc", dpc(0), 32'h100);
    check("redir_second_pc", dpc(1), 32'h104);

    // Misaligned redirect target is word-aligned
    force_redir = 1'b1; force_tgt = 32'h203;
    step();
    h0 = n_hs;
    for (int i = 0; i < 4; i++) if (n_hs == h0) step();
    check("redir_align_hs", {31'b0, n_hs > h0}, 32'd1);
    check("redir_align_addr", last_hs_addr, 32'h200);

    // Redirect coincident with the response for 0x4
    do_reset(32'h0);
    p_rsp = 0; p_instr_rdy = 0;
    repeat (3) step();
    p_rsp = 100;
    step();
    force_redir = 1'b1; force_tgt = 32'h300;
    step();
    check("rsp_coincident", {31'b0, seen_rsp_valid}, 32'd1);
    deliv_pcs.delete();
    p_instr_rdy = 100;
    repeat (8) step();
    check("coinc_first_pc", dpc(0), 32'h300);
    begin
      int n4 = 0;
      foreach (deliv_pcs[k]) if (deliv_pcs[k] == 32'h4) n4++;
      check("coinc_no_0x4", n4, 0);
    end

    // Reset with the queue full
    do_reset(32'h0);
    p_instr_rdy = 0;
    repeat (8) step();
    check("queue_full_valid", {31'b0, seen_instr_valid}, 32'd1);
    do_reset(32'h1234_5678);
    p_instr_rdy = 100;
    step();
    check("post_reset_req_valid", {31'b0, seen_req_valid}, 32'd1);
    check("post_reset_req_addr", last_hs_addr, RST_PC);

    // Randomized traffic with random redirects and occasional mid-stream resets
    do_reset($urandom());
    for (int b = 0; b < 40; b++) begin
      p_req_rdy   = $urandom_range(30, 100);
      p_rsp       = $urandom_range(20, 100);
      p_instr_rdy = $urandom_range(10, 100);
      p_redir     = $urandom_range(0, 8);
      if (b % 13 == 7) do_reset($urandom());
      repeat (75) step();
    end

    // Liveness after random traffic
    p_req_rdy = 100; p_rsp = 100; p_instr_rdy = 100; p_redir = 0;
    d0 = n_deliv;
    repeat (40) step();
    check("final_liveness", {31'b0, (n_deliv - d0) >= 20}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
